softmax_out_serializer: RTL and testbench

Downstream stage of the softmax vector unit. It captures the `Y_tile_out`/`tile_out_valid` tile stream, which has no backpressure, into a small tile FIFO. It then serializes each tile into a one-element-per-cycle valid/ready stream, drops the padding elements in a final partial tile, and marks the last element of each softmax vector. An optional checker confirms that each vector's outputs sum to 1.0 within a tolerance.

---
 rtl/softmax_out_serializer_if.sv | 27 ++
 rtl/softmax_out_serializer.sv | 178 +++++++++++++++++
 tb/tb_softmax_out_serializer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_out_serializer_if.sv
`default_nettype none
// ==========================================================================
// softmax_out_serializer_if : tile input and element output streams
// Rev 1.0
// ==========================================================================
interface softmax_out_serializer_if #(
  parameter int WIDTH     = 32,
  parameter int TILE_SIZE = 8
);
  logic [TILE_SIZE*WIDTH-1:0] tile_in;
  logic                       tile_in_valid;
  logic [WIDTH-1:0]           y_out;
  logic                       y_valid;
  logic                       y_ready;
  logic                       y_last;

  modport master (
    output tile_in, tile_in_valid, y_ready,
    input  y_out, y_valid, y_last
  );

  modport slave (
    input  tile_in, tile_in_valid, y_ready,
    output y_out, y_valid, y_last
  );
endinterface
`default_nettype wire

// File: rtl/softmax_out_serializer.sv
`default_nettype none
// ==========================================================================
// softmax_out_serializer : tile FIFO + per-element serializer with y_last;
// optional vector checksum when SOFTMAX_SER_CHECKSUM_EN is defined.
// Rev 1.0
// ==========================================================================
module softmax_out_serializer #(
  parameter int          WIDTH          = 32,
  parameter int          FRAC_WIDTH     = 16,
  parameter int          TOTAL_ELEMENTS = 64,
  parameter int          TILE_SIZE      = 8,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] SUM_TOL        = 32'h0000_0100
) (
  input  wire                            clk,
  input  wire                            rst_n,
  input  wire                            en,
  softmax_out_serializer_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  output logic                           sum_valid,
  output logic                           sum_ok
);

  localparam int TW = TILE_SIZE * WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int EW = (TOTAL_ELEMENTS > 1) ? $clog2(TOTAL_ELEMENTS) : 1;

  localparam logic [KW-1:0] K_LAST   = KW'(TILE_SIZE - 1);
  localparam logic [EW-1:0] E_LAST   = EW'(TOTAL_ELEMENTS - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_EMPTY  = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t          state;
  logic [TW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   hold_tile;
  logic [KW-1:0]   k;
  logic [EW-1:0]   e_out;

  logic hold_valid;
  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic last_elem;
  logic tile_done;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign hold_valid = (state == S_STREAM);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign last_elem  = (e_out == E_LAST);
  assign accept     = hold_valid && bus.y_ready && en;
  // A tile also ends early on y_last so trailing padding is never shown.
  assign tile_done  = accept && ((k == K_LAST) || last_elem);
  assign pop        = en && !fifo_empty && (!hold_valid || tile_done);
  assign push_req   = en && bus.tile_in_valid;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign bus.y_out   = hold_tile[TW-1 -: WIDTH];
  assign bus.y_valid = hold_valid;
  assign bus.y_last  = hold_valid && last_elem;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.tile_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      hold_tile <= '0;
      k         <= '0;
      e_out     <= '0;
    end else if (en) begin
      if (accept) begin
        e_out <= last_elem ? '0 : e_out + 1'b1;
      end
      case (state)
        S_EMPTY: begin
          if (pop) begin
            state     <= S_STREAM;
            hold_tile <= mem[rd_ptr];
            k         <= '0;
          end
        end
        S_STREAM: begin
          if (tile_done) begin
            k <= '0;
            if (pop) begin
              hold_tile <= mem[rd_ptr];
            end else begin
              state <= S_EMPTY;
            end
          end else if (accept) begin
            hold_tile <= hold_tile << WIDTH;
            k         <= k + 1'b1;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef SOFTMAX_SER_CHECKSUM_EN
  localparam int            SW  = WIDTH + $clog2(TOTAL_ELEMENTS + 1);
  localparam logic [SW-1:0] ONE = SW'(1) << FRAC_WIDTH;
  localparam logic [SW-1:0] TOL = SW'(SUM_TOL);

  logic [SW-1:0] acc;
  logic [SW-1:0] sum_next;
  logic [SW-1:0] diff;

  assign sum_next = acc + SW'(bus.y_out);
  assign diff     = (sum_next >= ONE) ? (sum_next - ONE) : (ONE - sum_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sum_valid <= 1'b0;
      sum_ok    <= 1'b0;
    end else if (en) begin
      sum_valid <= accept && last_elem;
      if (accept) begin
        if (last_elem) begin
          acc    <= '0;
          sum_ok <= (diff <= TOL);
        end else begin
          acc <= sum_next;
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{SUM_TOL, 32'(FRAC_WIDTH)};
  assign sum_valid  = 1'b0;
  assign sum_ok     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_out_serializer.sv
`default_nettype none
// ==========================================================================
// tb_softmax_out_serializer : three DUTs (64/20/16-element vectors) driven
// from a queue-based reference of the expected element stream.
// Rev 1.0
// ==========================================================================
module tb_softmax_out_serializer;
  localparam int W  = 32;
  localparam int T  = 8;
  localparam int TW = W * T;
  localparam int ND = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [TW-1:0] tin [ND];
  logic          tv  [ND];
  logic          yr  [ND];
  wire  [W-1:0]  yo  [ND];
  wire           yv  [ND];
  wire           yl  [ND];
  wire  [2:0]    lvl [ND];
  wire           ovf [ND];
  wire           sv  [ND];
  wire           sok [ND];

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  vec     [$];
  logic [W-1:0]  exp_val [$];
  bit            exp_last[$];
  bit            exp_ok  [$];
  logic [TW-1:0] tile_q  [$];

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      softmax_out_serializer_if #(.WIDTH(W), .TILE_SIZE(T)) bus ();
      assign bus.tile_in       = tin[g];
      assign bus.tile_in_valid = tv[g];
      assign bus.y_ready       = yr[g];
      assign yo[g]             = bus.y_out;
      assign yv[g]             = bus.y_valid;
      assign yl[g]             = bus.y_last;

      softmax_out_serializer #(
        .WIDTH          (W),
        .FRAC_WIDTH     (16),
        .TOTAL_ELEMENTS (g == 0 ? 64 : (g == 1 ? 20 : 16)),
        .TILE_SIZE      (T),
        .FIFO_DEPTH     (4),
        .SUM_TOL        (32'h0000_0100)
      ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bus        (bus),
        .fifo_level (lvl[g]),
        .overflow   (ovf[g]),
        .sum_valid  (sv[g]),
        .sum_ok     (sok[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] elem(input logic [TW-1:0] t, input int j);
    return t[TW-1-W*j -: W];
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int j = 0; j < T; j++) t[W*j +: W] = $urandom();
    return t;
  endfunction

  task automatic clear_model();
    exp_val.delete(); exp_last.delete(); exp_ok.delete(); tile_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin tv[d] = 1'b0; yr[d] = 1'b0; end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_model();
  endtask

  task automatic rand_vec(input int n);
    vec.delete();
    for (int i = 0; i < n; i++) vec.push_back($urandom());
  endtask

  // Expected stream is the vector itself; tiles carry random junk as padding.
  task automatic add_vector(input int n);
    longint s = 0;
    longint diff;
    logic [TW-1:0] t;
    for (int i = 0; i < n; i++) begin
      exp_val.push_back(vec[i]);
      exp_last.push_back(i == n - 1);
      s += longint'(vec[i]);
    end
    diff = (s > 65536) ? s - 65536 : 65536 - s;
    exp_ok.push_back(diff <= 256);
    for (int b = 0; b < n; b += T) begin
      t = '0;
      for (int j = 0; j < T; j++)
        t[TW-1-W*j -: W] = (b + j < n) ? vec[b+j] : W'($urandom());
      tile_q.push_back(t);
    end
  endtask

  // Pushes queued tiles as space allows and checks every accepted element.
  task automatic run(input int d, input int mode, input string name);
    bit stalled = 0, r, sv_exp = 0, ok_exp = 0, el;
    logic [W-1:0] po = '0, ev;
    logic pl = 1'b0;
    int cyc = 0;
    while ((exp_val.size() > 0 || tile_q.size() > 0 || sv_exp) && cyc < 4000) begin
      checks++;
      if (sv[d] !== sv_exp) begin
        errors++;
        $display("FAIL %s sum_valid: got %b expected %b", name, sv[d], sv_exp);
      end
      if (sv_exp) begin
        checks++;
        if (sok[d] !== ok_exp) begin
          errors++;
          $display("FAIL %s sum_ok: got %b expected %b", name, sok[d], ok_exp);
        end
      end
      sv_exp = 0;
      if (stalled) begin
        checks++;
        if (yv[d] !== 1'b1 || yo[d] !== po || yl[d] !== pl) begin
          errors++;
          $display("FAIL %s stall hold: got v=%b y=%h l=%b expected v=1 y=%h l=%b",
                   name, yv[d], yo[d], yl[d], po, pl);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      yr[d] = r;
      tv[d] = 1'b0;
      if (tile_q.size() > 0 && lvl[d] < 3'd4) begin
        tin[d] = tile_q.pop_front();
        tv[d]  = 1'b1;
      end
      stalled = 0;
      if (yv[d] === 1'b1 && r) begin
        checks++;
        if (exp_val.size() == 0) begin
          errors++;
          $display("FAIL %s extra element: got %h expected none", name, yo[d]);
        end else begin
          ev = exp_val.pop_front();
          el = exp_last.pop_front();
          if (yo[d] !== ev || yl[d] !== el) begin
            errors++;
            $display("FAIL %s element: got %h last=%b expected %h last=%b",
                     name, yo[d], yl[d], ev, el);
          end
          if (el && exp_ok.size() > 0) begin
            ok_exp = exp_ok.pop_front();
`ifdef SOFTMAX_SER_CHECKSUM_EN
            sv_exp = 1;
`endif
          end
        end
      end else if (yv[d] === 1'b1) begin
        stalled = 1;
        po = yo[d];
        pl = yl[d];
      end
      cyc++;
      step();
    end
    yr[d] = 1'b0;
    tv[d] = 1'b0;
    checks++;
    if (exp_val.size() != 0 || tile_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: got %0d elements left expected 0", name, exp_val.size());
    end
    checks++;
    if (yv[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle valid: got %b expected 0", name, yv[d]);
    end
    clear_model();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({yv[d], yl[d], ovf[d], sv[d], sok[d]} !== 5'b0 || lvl[d] !== 3'd0 || yo[d] !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: got v=%b l=%b ovf=%b sv=%b ok=%b lvl=%0d y=%h expected all 0",
                 d, yv[d], yl[d], ovf[d], sv[d], sok[d], lvl[d], yo[d]);
      end
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_rate();
    vec.delete();
    for (int i = 0; i < 64; i++) vec.push_back(32'h400 * (i + 1));
    add_vector(64);
    yr[0] = 1'b1;
    for (int c = 0; c < 72; c++) begin
      if (c % 8 == 0 && tile_q.size() > 0) begin
        tin[0] = tile_q.pop_front();
        tv[0]  = 1'b1;
      end else begin
        tv[0] = 1'b0;
      end
      checks++;
      if (c >= 2 && c < 66) begin
        if (yv[0] !== 1'b1 || yo[0] !== exp_val[c-2] || yl[0] !== exp_last[c-2]) begin
          errors++;
          $display("FAIL full_rate c%0d: got v=%b y=%h l=%b expected v=1 y=%h l=%b",
                   c, yv[0], yo[0], yl[0], exp_val[c-2], exp_last[c-2]);
        end
      end else if (yv[0] !== 1'b0) begin
        errors++;
        $display("FAIL full_rate c%0d valid: got %b expected 0", c, yv[0]);
      end
      step();
    end
    yr[0] = 1'b0;
    tv[0] = 1'b0;
    clear_model();
  endtask

  task automatic test_backpressure();
    rand_vec(64);
    add_vector(64);
    run(0, 1, "backpressure");
  endtask

  task automatic test_overflow();
    logic [TW-1:0] tl [7];
    for (int i = 0; i < 7; i++) tl[i] = rand_tile();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tin[0] = tl[i];
      tv[0]  = 1'b1;
      if (i == 5) begin
        checks++;
        if (lvl[0] !== 3'd4 || ovf[0] !== 1'b0 || yv[0] !== 1'b1 || yo[0] !== elem(tl[0], 0)) begin
          errors++;
          $display("FAIL ovf fill: got lvl=%0d ovf=%b v=%b y=%h expected lvl=4 ovf=0 v=1 y=%h",
                   lvl[0], ovf[0], yv[0], yo[0], elem(tl[0], 0));
        end
      end
      step();
    end
    tv[0] = 1'b0;
    checks++;
    if (ovf[0] !== 1'b1 || lvl[0] !== 3'd4) begin
      errors++;
      $display("FAIL ovf drop: got ovf=%b lvl=%0d expected ovf=1 lvl=4", ovf[0], lvl[0]);
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < T; j++) begin exp_val.push_back(elem(tl[i], j)); exp_last.push_back(1'b0); end
    run(0, 2, "ovf_drain");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      tin[0] = tl[i];
      tv[0]  = 1'b1;
      step();
    end
    tv[0] = 1'b0;
    yr[0] = 1'b1;
    for (int c = 0; c < T; c++) begin
      if (c == T - 1) begin tin[0] = tl[6]; tv[0] = 1'b1; end
      checks++;
      if (yv[0] !== 1'b1 || yo[0] !== elem(tl[0], c)) begin
        errors++;
        $display("FAIL popedge elem%0d: got v=%b y=%h expected v=1 y=%h", c, yv[0], yo[0], elem(tl[0], c));
      end
      step();
    end
    tv[0] = 1'b0;
    yr[0] = 1'b0;
    checks++;
    if (ovf[0] !== 1'b0 || lvl[0] !== 3'd4) begin
      errors++;
      $display("FAIL popedge push: got ovf=%b lvl=%0d expected ovf=0 lvl=4", ovf[0], lvl[0]);
    end
    for (int i = 1; i < 7; i++) begin
      if (i == 5) continue;
      for (int j = 0; j < T; j++) begin exp_val.push_back(elem(tl[i], j)); exp_last.push_back(1'b0); end
    end
    run(0, 0, "popedge_drain");
    do_reset();
  endtask

  task automatic test_partial();
    for (int v = 0; v < 2; v++) begin rand_vec(20); add_vector(20); end
    run(1, 0, "partial");
  endtask

  task automatic test_checksum();
    int pos;
    for (int v = 0; v < 5; v++) begin
      vec.delete();
      for (int i = 0; i < 16; i++) vec.push_back(32'h1000);
      pos = int'($urandom_range(0, 15));
      case (v)
        1:       vec[pos] = 32'h1200;
        2:       vec[pos] = 32'h1100;
        3:       vec[pos] = 32'h0F00;
        4:       vec[pos] = 32'h1101;
        default: ;
      endcase
      add_vector(16);
    end
    run(2, 2, "checksum");
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 3; v++) begin rand_vec(20); add_vector(20); end
    run(1, 2, "b2b_20");
    for (int v = 0; v < 2; v++) begin rand_vec(64); add_vector(64); end
    run(0, 2, "b2b_64");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ev;
    bit el;
    rand_vec(64);
    add_vector(64);
    yr[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tin[0] = tile_q.pop_front();
      tv[0]  = 1'b1;
      step();
    end
    tv[0] = 1'b0;
    checks++;
    if (ovf[0] !== 1'b1 || lvl[0] !== 3'd4) begin
      errors++;
      $display("FAIL mid setup: got ovf=%b lvl=%0d expected ovf=1 lvl=4", ovf[0], lvl[0]);
    end
    yr[0] = 1'b1;
    for (int a = 0; a < 30; a++) begin
      ev = exp_val.pop_front();
      el = exp_last.pop_front();
      checks++;
      if (yv[0] !== 1'b1 || yo[0] !== ev || yl[0] !== el) begin
        errors++;
        $display("FAIL mid elem%0d: got v=%b y=%h l=%b expected v=1 y=%h l=%b",
                 a, yv[0], yo[0], yl[0], ev, el);
      end
      step();
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (yv[0] !== 1'b0 || yl[0] !== 1'b0 || ovf[0] !== 1'b0 || lvl[0] !== 3'd0) begin
      errors++;
      $display("FAIL mid async reset: got v=%b l=%b ovf=%b lvl=%0d expected all 0",
               yv[0], yl[0], ovf[0], lvl[0]);
    end
    yr[0] = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_model();
    rand_vec(64);
    add_vector(64);
    run(0, 2, "post_reset");
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    for (int d = 0; d < ND; d++) begin tin[d] = '0; tv[d] = 1'b0; yr[d] = 1'b0; end
    test_reset();
    test_full_rate();
    test_backpressure();
    test_overflow();
    test_partial();
    test_checksum();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
